mem_arbiter: RTL

- Shares the single SDRAM memory controller port between four clients: the periodic refresh timer, the super-res renderer (32-bit reads), the command engine (8/32-bit reads and writes) and the CPU VRAM port (8-bit reads and writes).
- Sits directly upstream of the memory controller.
- Owns refresh scheduling, fixed priority with a CPU starvation guard, sequencing of the controller's read/write/refresh strobes, and return-data steering.

---
 rtl/mem_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single SDRAM controller port between refresh, renderer, command engine and CPU.
// Owns refresh scheduling, fixed priority with a CPU starvation guard, strobe sequencing and read-data steering.
module mem_arbiter #(
    parameter int FREQ           = 54_000_000,
    parameter int REFRESH_CYCLES = (FREQ / 1_000_000) * 7,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rend_req,
    input  logic [22:0] rend_addr,
    output logic        rend_ack,
    output logic [31:0] rend_data,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [1:0]  cmd_size,
    input  logic [22:0] cmd_addr,
    input  logic [7:0]  cmd_din8,
    input  logic [31:0] cmd_din32,
    output logic        cmd_ack,
    output logic [31:0] cmd_dout32,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_refresh,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_word_size,
    output logic [7:0]  mem_din8,
    output logic [31:0] mem_din32,
    input  logic        mem_busy,
    input  logic        mem_enabled,
    input  logic [15:0] mem_dout16,
    input  logic [31:0] mem_dout32,
    output logic        size_error,
    output logic        refresh_overrun
);

    localparam logic [1:0] MEMORY_WIDTH_8  = 2'd0;
    localparam logic [1:0] MEMORY_WIDTH_16 = 2'd1;
    localparam logic [1:0] MEMORY_WIDTH_32 = 2'd2;

    localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic [1:0] {OWN_REF, OWN_REND, OWN_CMD, OWN_CPU} owner_t;

    state_t state, state_next;
    owner_t op_owner, grant_owner;

    logic [RC_W-1:0] refresh_cnt;
    logic            refresh_pending;
    logic [SC_W-1:0] starve_cnt;

    logic        op_read, op_illegal;
    logic [1:0]  op_cmd_size;
    logic        grant_ok, grant, grant_rd, grant_wr, grant_ref, grant_illegal;
    logic        cpu_promoted, done;
    logic [1:0]  grant_size;
    logic [22:0] grant_addr;
    logic [7:0]  grant_din8, sel_byte;
    logic [31:0] grant_din32, cmd_rd_data;
    logic        rd_d, wr_d, ref_d, rend_ack_d, cmd_ack_d, cpu_ack_d;

    // Valid/ready: a client holds *_req high until its *_ack pulse (one cycle);
    // the controller accepts a strobe only while mem_busy is low.
    // An ack cycle blocks a new grant so the acked client can drop its request first.
    assign grant_ok     = (state == IDLE) && mem_enabled && !mem_busy &&
                          !rend_ack && !cmd_ack && !cpu_ack;
    assign cpu_promoted = cpu_req && (starve_cnt >= SC_MAX);
    assign done         = (state == WAIT_DONE) && !mem_busy;
    assign sel_byte     = mem_addr[0] ? mem_dout16[15:8] : mem_dout16[7:0];

    always_comb begin
        case (op_cmd_size)
            MEMORY_WIDTH_8:  cmd_rd_data = {24'b0, sel_byte};
            MEMORY_WIDTH_16: cmd_rd_data = {16'b0, mem_dout16};
            default:         cmd_rd_data = mem_dout32;
        endcase
    end

    always_comb begin
        grant         = 1'b0;
        grant_owner   = OWN_REF;
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;
        grant_ref     = 1'b0;
        grant_illegal = 1'b0;
        grant_size    = MEMORY_WIDTH_8;
        grant_addr    = '0;
        grant_din8    = '0;
        grant_din32   = '0;
        if (grant_ok) begin
            if (refresh_pending) begin
                grant       = 1'b1;
                grant_owner = OWN_REF;
                grant_ref   = 1'b1;
            end else if (rend_req) begin
                grant       = 1'b1;
                grant_owner = OWN_REND;
                grant_rd    = 1'b1;
                grant_size  = MEMORY_WIDTH_32;
                grant_addr  = rend_addr;
            end else if (cmd_req && !cpu_promoted) begin
                grant       = 1'b1;
                grant_owner = OWN_CMD;
                grant_addr  = cmd_addr;
                grant_din8  = cmd_din8;
                grant_din32 = cmd_din32;
                // Byte reads go out as 16-bit reads and are narrowed on return.
                case (cmd_size)
                    MEMORY_WIDTH_8: begin
                        grant_size = cmd_wr ? MEMORY_WIDTH_8 : MEMORY_WIDTH_16;
                        grant_wr   = cmd_wr;
                        grant_rd   = !cmd_wr;
                    end
                    MEMORY_WIDTH_16: begin
                        grant_size    = MEMORY_WIDTH_16;
                        grant_illegal = cmd_wr;
                        grant_rd      = !cmd_wr;
                    end
                    default: begin
                        grant_size = MEMORY_WIDTH_32;
                        grant_wr   = cmd_wr;
                        grant_rd   = !cmd_wr;
                    end
                endcase
            end else if (cpu_req) begin
                grant       = 1'b1;
                grant_owner = OWN_CPU;
                grant_addr  = cpu_addr;
                grant_din8  = cpu_din;
                grant_size  = cpu_wr ? MEMORY_WIDTH_8 : MEMORY_WIDTH_16;
                grant_wr    = cpu_wr;
                grant_rd    = !cpu_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (grant) state_next = ISSUE;
            ISSUE:     state_next = op_illegal ? IDLE : WAIT_BUSY;
            WAIT_BUSY: if (mem_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!mem_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Strobes and acks are computed one cycle ahead and registered, so the
    // strobe lands exactly in ISSUE and the ack in the cycle after WAIT_DONE.
    always_comb begin
        rd_d       = grant_rd;
        wr_d       = grant_wr;
        ref_d      = grant_ref;
        rend_ack_d = done && (op_owner == OWN_REND);
        cmd_ack_d  = (done && (op_owner == OWN_CMD)) || grant_illegal;
        cpu_ack_d  = done && (op_owner == OWN_CPU);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_refresh   <= 1'b0;
            mem_addr      <= '0;
            mem_word_size <= MEMORY_WIDTH_8;
            mem_din8      <= '0;
            mem_din32     <= '0;
            op_owner      <= OWN_REF;
            op_read       <= 1'b0;
            op_illegal    <= 1'b0;
            op_cmd_size   <= '0;
            rend_ack      <= 1'b0;
            cmd_ack       <= 1'b0;
            cpu_ack       <= 1'b0;
            rend_data     <= '0;
            cmd_dout32    <= '0;
            cpu_dout      <= '0;
            size_error    <= 1'b0;
        end else begin
            mem_read    <= rd_d;
            mem_write   <= wr_d;
            mem_refresh <= ref_d;
            rend_ack    <= rend_ack_d;
            cmd_ack     <= cmd_ack_d;
            cpu_ack     <= cpu_ack_d;
            if (grant) begin
                mem_addr      <= grant_addr;
                mem_word_size <= grant_size;
                mem_din8      <= grant_din8;
                mem_din32     <= grant_din32;
                op_owner      <= grant_owner;
                op_read       <= grant_rd;
                op_illegal    <= grant_illegal;
                op_cmd_size   <= cmd_size;
            end
            if (grant_illegal) size_error <= 1'b1;
            if (rend_ack_d) rend_data <= mem_dout32;
            if (done && (op_owner == OWN_CMD) && op_read) cmd_dout32 <= cmd_rd_data;
            if (done && (op_owner == OWN_CPU) && op_read) cpu_dout <= sel_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
        end else begin
            if (done && (op_owner == OWN_REF)) refresh_pending <= 1'b0;
            if (mem_enabled) begin
                if (refresh_cnt == RC_LAST) begin
                    refresh_cnt     <= '0;
                    refresh_pending <= 1'b1;
                    if (refresh_pending) refresh_overrun <= 1'b1;
                end else begin
                    refresh_cnt <= refresh_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !cpu_req) begin
            starve_cnt <= '0;
        end else if (grant && (grant_owner == OWN_CPU)) begin
            starve_cnt <= '0;
        end else if (grant && (grant_owner == OWN_CMD) && (starve_cnt < SC_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
